sh7604_rst_sby_ctrl: RTL and testbench
======================================

// Module: sh7604_rst_sby_ctrl
// PURPOSE
//  Reset and standby sequencer sitting directly downstream of the SH7604 watchdog timer.
//  - Consumes the WDT reset requests (PRES/MRES), the standby-timer overflow (OVF) and the external RES_N pin.
//  - Produces the internal reset (RES_N_INT) that feeds RES_N of WDT, FRT, SCI, DMAC and the CPU core.
//  - Produces SBY (fed to WDT.SBY) and the clock-stop request for software standby.
//  - Latches the reset cause for the CPU to read.
// PARAMETERS
//  FILT_TICKS  4    CE_R ticks RES_N must be stable low before an external reset is accepted
//  HOLD_TICKS  16   CE_R ticks RES_N_INT is held low after every reset source has been released
//  WAKE_TMO    4096 CE_R ticks to wait for WDT OVF in WAKE before forcing RUN (0 = wait forever)
// PORTS
//  CLK        in   1  system clock
//  RST        in   1  synchronous active-high reset
//  CE_R       in   1  rising-phase clock enable; all state advances only when EN && CE_R
//  EN         in   1  global enable
//  RES_N      in   1  external reset pin, asynchronous, active low
//  NMI        in   1  NMI pin level (already synchronised)
//  SBY_REQ    in   1  one-tick pulse: CPU executed SLEEP with SBYCR.SBY=1
//  PRES       in   1  WDT power-on reset request (may last only 1 tick)
//  MRES       in   1  WDT manual reset request (may last only 1 tick)
//  WDT_OVF    in   1  WDT standby-timer overflow pulse
//  RES_N_INT  out  1  internal reset to all on-chip modules, active low
//  MAN_RES    out  1  1 = current/last reset was a manual reset
//  RST_CAUSE  out  2  00 = ext power-on, 01 = WDT power-on, 10 = WDT manual, 11 = never driven
//  SBY        out  1  standby active (to WDT.SBY)
//  CLK_STOP   out  1  request the clock generator to gate the CPU/peripheral clock
//  WAKE       out  1  one-tick pulse on a successful standby exit via NMI
// BEHAVIOUR
//  - Reset (RST=1) applies regardless of EN/CE_R.
//    - State HOLD, HOLD counter = HOLD_TICKS.
//    - RES_N_INT=0, MAN_RES=0, RST_CAUSE=00, SBY=0, CLK_STOP=0, WAKE=0, filter count 0.
//  - RES_N filter
//    - RES_N passes a 2-flop synchroniser on CLK.
//    - The filter count increments while the synchronised pin is low and clears when it is high.
//    - ext_rst asserts once the count reaches FILT_TICKS and deasserts on the first high sample.
//  - Source priority, evaluated each tick: ext_rst > PRES > MRES > SBY_REQ/NMI/WDT_OVF.
//  - Any reset source, in any state, moves the block to HOLD and reloads the counter.
//    - Cause updates: ext_rst -> RST_CAUSE=00, MAN_RES=0; PRES -> 01, MAN_RES=0; MRES -> 10, MAN_RES=1.
//    - PRES/MRES are latched in the same tick they are seen. RES_N_INT falling clears them in the WDT.
//  - States
//    - HOLD
//      - RES_N_INT=0, SBY=0, CLK_STOP=0.
//      - The counter reloads while ext_rst=1 and otherwise decrements per tick.
//      - At counter==1 the next tick enters RUN with RES_N_INT=1, giving exactly HOLD_TICKS low ticks after release.
//    - RUN
//      - RES_N_INT=1.
//      - SBY_REQ -> STBY; SBY=1 and CLK_STOP=1 on the next tick.
//    - STBY
//      - SBY=1, CLK_STOP=1.
//      - An NMI rising edge (NMI=1, previous tick 0) -> WAKE state; CLK_STOP=0 and SBY stays 1, so the WDT standby timer runs.
//      - The NMI edge detector is updated every tick in all states; a level held high on entry does not wake.
//    - WAKE
//      - WDT_OVF -> RUN; SBY=0, WAKE=1 for one tick.
//      - If WAKE_TMO!=0 and WAKE_TMO ticks elapse without WDT_OVF -> RUN with WAKE=1. The timeout counter is cleared on entry.
//  - Simultaneous events
//    - SBY_REQ together with a reset source: the reset wins and standby is never entered.
//    - WDT_OVF together with ext_rst in WAKE: HOLD wins.
//  - Counters
//    - Width $clog2(max param)+1.
//    - No wrap-around: the HOLD counter saturates at 0, the WAKE counter saturates at WAKE_TMO.
//  - With EN=0 or CE_R=0 all state holds and outputs stay unchanged. WAKE is cleared after one CE_R tick.
// TESTING
//  - RST 1->0, RES_N=1 -> RES_N_INT low for exactly 16 CE_R ticks, then 1; RST_CAUSE=00.
//  - RES_N low for 3 ticks -> ignored. Low for 4 ticks, then high -> RES_N_INT=0 from the acceptance tick and releases 16 ticks after the first high sample.
//  - PRES for 1 tick in RUN -> RES_N_INT=0 next tick, RST_CAUSE=01, MAN_RES=0. MRES for 1 tick -> RST_CAUSE=10, MAN_RES=1, 16-tick hold.
//  - Standby exit: SBY_REQ -> SBY=1, CLK_STOP=1. NMI held high from entry -> stays in STBY. NMI 0->1 -> CLK_STOP=0. WDT_OVF -> SBY=0 with a single WAKE pulse.
//  - WAKE_TMO=8 with no WDT_OVF -> RUN after 8 ticks in WAKE. ext_rst during WAKE -> HOLD with SBY=0.
//  - SBY_REQ and MRES in the same tick -> HOLD, SBY stays 0. Assert RST mid-HOLD -> counter reloads to 16.

Source files
------------

// File: rtl/sh7604_rst_sby_ctrl.sv
// SH7604 reset and standby sequencer: filters the external reset pin,
// arbitrates WDT reset requests, stretches the internal reset and walks
// the software-standby entry/exit handshake with the WDT.
module sh7604_rst_sby_ctrl #(
  parameter int unsigned FILT_TICKS = 4,
  parameter int unsigned HOLD_TICKS = 16,
  parameter int unsigned WAKE_TMO   = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce_r,
  input  logic       i_en,
  input  logic       i_res_n,
  input  logic       i_nmi,
  input  logic       i_sby_req,
  input  logic       i_pres,
  input  logic       i_mres,
  input  logic       i_wdt_ovf,
  output logic       o_res_n_int,
  output logic       o_man_res,
  output logic [1:0] o_rst_cause,
  output logic       o_sby,
  output logic       o_clk_stop,
  output logic       o_wake
);

  localparam int unsigned MAXP =
    (FILT_TICKS > HOLD_TICKS) ? ((FILT_TICKS > WAKE_TMO) ? FILT_TICKS : WAKE_TMO)
                              : ((HOLD_TICKS > WAKE_TMO) ? HOLD_TICKS : WAKE_TMO);
  localparam int unsigned CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] FILT_C    = CW'(FILT_TICKS);
  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] WAKE_C    = CW'(WAKE_TMO);
  localparam logic [CW-1:0] WAKE_LAST = (WAKE_TMO == 0) ? '0 : CW'(WAKE_TMO - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_STBY = 2'd2,
    S_WAKE = 2'd3
  } state_t;

  state_t          r_state, w_state_nx;
  logic [1:0]      r_res_sync;
  logic [CW-1:0]   r_filt_cnt, w_filt_nx, w_filt_sat;
  logic [CW-1:0]   r_hold_cnt, w_hold_nx;
  logic [CW-1:0]   r_wake_cnt, w_wake_cnt_nx;
  logic [1:0]      r_cause, w_cause_nx;
  logic            r_man_res, w_man_nx;
  logic            r_wake, w_wake_nx;
  logic            r_nmi_prev;
  logic            w_tick, w_pin_low, w_ext_rst, w_nmi_rise;

  assign w_tick     = i_en & i_ce_r;
  assign w_pin_low  = ~r_res_sync[1];
  assign w_filt_sat = (r_filt_cnt >= FILT_C) ? FILT_C : r_filt_cnt + CW'(1);
  // Acceptance is seen in the same tick that the low count reaches the threshold.
  assign w_ext_rst  = w_pin_low && (w_filt_sat >= FILT_C);
  assign w_nmi_rise = i_nmi & ~r_nmi_prev;

  // Two-flop synchroniser for the asynchronous external reset pin.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_res_sync <= '1;
    else       r_res_sync <= {r_res_sync[0], i_res_n};
  end

  // Next-state, counter and cause arbitration; reset sources dominate every state.
  always_comb begin
    w_state_nx    = r_state;
    w_hold_nx     = r_hold_cnt;
    w_wake_cnt_nx = r_wake_cnt;
    w_cause_nx    = r_cause;
    w_man_nx      = r_man_res;
    w_wake_nx     = 1'b0;
    w_filt_nx     = w_pin_low ? w_filt_sat : '0;

    if (w_ext_rst || i_pres || i_mres) begin
      w_state_nx    = S_HOLD;
      w_hold_nx     = HOLD_C;
      w_wake_cnt_nx = '0;
      if (w_ext_rst) begin
        w_cause_nx = 2'b00;
        w_man_nx   = 1'b0;
      end else if (i_pres) begin
        w_cause_nx = 2'b01;
        w_man_nx   = 1'b0;
      end else begin
        w_cause_nx = 2'b10;
        w_man_nx   = 1'b1;
      end
    end else begin
      case (r_state)
        S_HOLD: begin
          w_hold_nx = (r_hold_cnt != '0) ? r_hold_cnt - CW'(1) : '0;
          if (r_hold_cnt <= CW'(1)) w_state_nx = S_RUN;
        end
        S_RUN: begin
          if (i_sby_req) w_state_nx = S_STBY;
        end
        S_STBY: begin
          if (w_nmi_rise) begin
            w_state_nx    = S_WAKE;
            w_wake_cnt_nx = '0;
          end
        end
        S_WAKE: begin
          if (i_wdt_ovf || (WAKE_TMO != 0 && r_wake_cnt >= WAKE_LAST)) begin
            w_state_nx = S_RUN;
            w_wake_nx  = 1'b1;
          end else if (r_wake_cnt < WAKE_C) begin
            w_wake_cnt_nx = r_wake_cnt + CW'(1);
          end
        end
        default: w_state_nx = S_HOLD;
      endcase
    end
  end

  // State and counter registers, advanced only on enabled rising-phase ticks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= HOLD_C;
      r_wake_cnt <= '0;
      r_filt_cnt <= '0;
      r_cause    <= 2'b00;
      r_man_res  <= 1'b0;
      r_wake     <= 1'b0;
      r_nmi_prev <= 1'b0;
    end else if (w_tick) begin
      r_state    <= w_state_nx;
      r_hold_cnt <= w_hold_nx;
      r_wake_cnt <= w_wake_cnt_nx;
      r_filt_cnt <= w_filt_nx;
      r_cause    <= w_cause_nx;
      r_man_res  <= w_man_nx;
      r_wake     <= w_wake_nx;
      r_nmi_prev <= i_nmi;
    end
  end

  assign o_res_n_int = (r_state != S_HOLD);
  assign o_sby       = (r_state == S_STBY) || (r_state == S_WAKE);
  assign o_clk_stop  = (r_state == S_STBY);
  assign o_wake      = r_wake;
  assign o_rst_cause = r_cause;
  assign o_man_res   = r_man_res;

endmodule

// File: tb/tb_sh7604_rst_sby_ctrl.sv
// Directed bench for the SH7604 reset/standby sequencer.
module tb_sh7604_rst_sby_ctrl;

  logic       clk = 1'b0;
  logic       rst, ce_r, en, res_n, nmi, sby_req, pres, mres, wdt_ovf;
  logic       res_n_int, man_res, sby, clk_stop, wake;
  logic [1:0] rst_cause;

  int checks   = 0;
  int failures = 0;

  sh7604_rst_sby_ctrl #(
    .FILT_TICKS(4),
    .HOLD_TICKS(16),
    .WAKE_TMO  (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ce_r     (ce_r),
    .i_en       (en),
    .i_res_n    (res_n),
    .i_nmi      (nmi),
    .i_sby_req  (sby_req),
    .i_pres     (pres),
    .i_mres     (mres),
    .i_wdt_ovf  (wdt_ovf),
    .o_res_n_int(res_n_int),
    .o_man_res  (man_res),
    .o_rst_cause(rst_cause),
    .o_sby      (sby),
    .o_clk_stop (clk_stop),
    .o_wake     (wake)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for RES_N_INT to release.
  task automatic wait_run(input string name);
    int n = 0;
    while (res_n_int !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (res_n_int !== 1'b1) begin
      failures++;
      $display("FAIL %s: res_n_int=%b required 1 within 40 ticks", name, res_n_int);
    end
  endtask

  // Walks 16 hold ticks: low through tick 15, high after tick 16.
  task automatic check_hold16(input string name);
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (res_n_int !== (i == 16)) begin
        failures++;
        $display("FAIL %s tick %0d: res_n_int=%b required %b", name, i, res_n_int, (i == 16));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_r = 1'b1; en = 1'b1; res_n = 1'b1; nmi = 1'b0;
    sby_req = 1'b0; pres = 1'b0; mres = 1'b0; wdt_ovf = 1'b0;
    tick(); tick();
    checks++;
    if ({res_n_int, man_res, rst_cause, sby, clk_stop, wake} !== 7'b0_0_00_0_0_0) begin
      failures++;
      $display("FAIL reset_state: got %b required 0000000",
               {res_n_int, man_res, rst_cause, sby, clk_stop, wake});
    end
    rst = 1'b0;
    check_hold16("reset_hold");
    checks++;
    if (rst_cause !== 2'b00) begin
      failures++;
      $display("FAIL reset_cause: got %b required 00", rst_cause);
    end
  endtask

  task automatic test_pres_mres();
    pres = 1'b1; tick(); pres = 1'b0;
    checks++;
    if ({res_n_int, rst_cause, man_res} !== 4'b0_01_0) begin
      failures++;
      $display("FAIL pres_cause: got %b required 0010", {res_n_int, rst_cause, man_res});
    end
    check_hold16("pres_hold");
    mres = 1'b1; tick(); mres = 1'b0;
    checks++;
    if ({res_n_int, rst_cause, man_res} !== 4'b0_10_1) begin
      failures++;
      $display("FAIL mres_cause: got %b required 0101", {res_n_int, rst_cause, man_res});
    end
    check_hold16("mres_hold");
  endtask

  task automatic test_ext_filter();
    res_n = 1'b0; tick(); tick(); tick(); res_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (res_n_int !== 1'b1) begin
        failures++;
        $display("FAIL ext_short_pulse tick %0d: res_n_int=%b required 1", i, res_n_int);
      end
    end
    res_n = 1'b0; tick(); tick(); tick(); tick(); res_n = 1'b1;
    tick();
    checks++;
    if (res_n_int !== 1'b1) begin
      failures++;
      $display("FAIL ext_before_accept: res_n_int=%b required 1", res_n_int);
    end
    tick();
    checks++;
    if ({res_n_int, rst_cause, man_res} !== 4'b0_00_0) begin
      failures++;
      $display("FAIL ext_accept: got %b required 0000", {res_n_int, rst_cause, man_res});
    end
    check_hold16("ext_hold");
  endtask

  task automatic test_standby();
    nmi = 1'b1; sby_req = 1'b1; tick(); sby_req = 1'b0;
    checks++;
    if ({sby, clk_stop} !== 2'b11) begin
      failures++;
      $display("FAIL stby_entry: sby,clk_stop=%b required 11", {sby, clk_stop});
    end
    tick(); tick(); tick();
    checks++;
    if ({sby, clk_stop} !== 2'b11) begin
      failures++;
      $display("FAIL stby_nmi_level: sby,clk_stop=%b required 11", {sby, clk_stop});
    end
    nmi = 1'b0; tick(); nmi = 1'b1; tick();
    checks++;
    if ({sby, clk_stop, wake} !== 3'b100) begin
      failures++;
      $display("FAIL stby_nmi_edge: sby,clk_stop,wake=%b required 100", {sby, clk_stop, wake});
    end
    tick(); tick();
    checks++;
    if ({sby, clk_stop} !== 2'b10) begin
      failures++;
      $display("FAIL wake_wait: sby,clk_stop=%b required 10", {sby, clk_stop});
    end
    wdt_ovf = 1'b1; tick(); wdt_ovf = 1'b0;
    checks++;
    if ({res_n_int, sby, clk_stop, wake} !== 4'b1001) begin
      failures++;
      $display("FAIL wake_ovf: res_n_int,sby,clk_stop,wake=%b required 1001",
               {res_n_int, sby, clk_stop, wake});
    end
    tick();
    checks++;
    if (wake !== 1'b0) begin
      failures++;
      $display("FAIL wake_pulse_width: wake=%b required 0", wake);
    end
    nmi = 1'b0;
  endtask

  task automatic test_wake_timeout();
    sby_req = 1'b1; tick(); sby_req = 1'b0;
    nmi = 1'b1; tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({sby, wake} !== ((i == 8) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL wake_timeout tick %0d: sby,wake=%b required %b",
                 i, {sby, wake}, ((i == 8) ? 2'b01 : 2'b10));
      end
    end
    ce_r = 1'b0; tick(); tick();
    checks++;
    if (wake !== 1'b1) begin
      failures++;
      $display("FAIL wake_hold_no_ce: wake=%b required 1", wake);
    end
    ce_r = 1'b1; tick();
    checks++;
    if (wake !== 1'b0) begin
      failures++;
      $display("FAIL wake_clear_on_ce: wake=%b required 0", wake);
    end
    nmi = 1'b0;
  endtask

  task automatic test_ext_in_wake();
    sby_req = 1'b1; tick(); sby_req = 1'b0;
    tick(); nmi = 1'b1; tick();
    res_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({res_n_int, sby, clk_stop} !== 3'b110) begin
      failures++;
      $display("FAIL ext_wake_pre: res_n_int,sby,clk_stop=%b required 110", {res_n_int, sby, clk_stop});
    end
    wdt_ovf = 1'b1; tick(); wdt_ovf = 1'b0;
    checks++;
    if ({res_n_int, sby, clk_stop, wake} !== 4'b0000) begin
      failures++;
      $display("FAIL ext_vs_ovf: res_n_int,sby,clk_stop,wake=%b required 0000",
               {res_n_int, sby, clk_stop, wake});
    end
    res_n = 1'b1; nmi = 1'b0;
    wait_run("ext_wake_release");
  endtask

  task automatic test_sby_mres_same();
    sby_req = 1'b1; mres = 1'b1; tick(); sby_req = 1'b0; mres = 1'b0;
    checks++;
    if ({res_n_int, sby, clk_stop, rst_cause, man_res} !== 6'b000_10_1) begin
      failures++;
      $display("FAIL sby_mres: res_n_int,sby,clk_stop,cause,man=%b required 000101",
               {res_n_int, sby, clk_stop, rst_cause, man_res});
    end
    wait_run("sby_mres_release");
    checks++;
    if (sby !== 1'b0) begin
      failures++;
      $display("FAIL sby_mres_after: sby=%b required 0", sby);
    end
  endtask

  task automatic test_rst_mid_hold();
    pres = 1'b1; tick(); pres = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({res_n_int, rst_cause, man_res} !== 4'b0_00_0) begin
      failures++;
      $display("FAIL rst_mid_hold: res_n_int,cause,man=%b required 0000", {res_n_int, rst_cause, man_res});
    end
    check_hold16("rst_mid_hold_reload");
  endtask

  task automatic test_gating();
    ce_r = 1'b0; pres = 1'b1; tick(); tick();
    checks++;
    if (res_n_int !== 1'b1) begin
      failures++;
      $display("FAIL gate_ce: res_n_int=%b required 1", res_n_int);
    end
    ce_r = 1'b1; en = 1'b0; tick(); tick();
    checks++;
    if (res_n_int !== 1'b1) begin
      failures++;
      $display("FAIL gate_en: res_n_int=%b required 1", res_n_int);
    end
    en = 1'b1; tick(); pres = 1'b0;
    checks++;
    if ({res_n_int, rst_cause} !== 3'b0_01) begin
      failures++;
      $display("FAIL gate_resume: res_n_int,cause=%b required 001", {res_n_int, rst_cause});
    end
    wait_run("gate_release");
  endtask

  initial begin
    test_reset();
    test_pres_mres();
    test_ext_filter();
    test_standby();
    test_wake_timeout();
    test_ext_in_wake();
    test_sby_mres_same();
    test_rst_mid_hold();
    test_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
